mem_store_narrow: RTL

MEM_STORE_NARROW -- requirements
Module: mem_store_narrow

---
 rtl/mem_store_narrow.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/mem_store_narrow.sv
// mem_store_narrow: narrow (byte/halfword) and word store unit.
// Byte and halfword stores are read-modify-write on a full-word memory port.
// Word stores write directly. Malformed requests complete with an error code and
// do not touch memory.
// Optional feature: define STORE_RANGE_CHECK_EN to reject byte/half values that
// do not fit the narrow width (signed or unsigned, per req_signed).
module mem_store_narrow #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    output logic              done_valid,
    output logic              done_err,
    output logic [1:0]        err_code
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        DONE  = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_SIZE     = 2'b10,
        ERR_RANGE    = 2'b11
    } err_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    size_t             size_q, size_d;
    err_t              err_q, err_d;

    logic              accept;
    logic              range_ok;
    err_t              chk_err;
    logic [31:0]       merged;

    assign accept = req_valid && (state_q == IDLE);

`ifdef STORE_RANGE_CHECK_EN
    // Narrow value must be representable: upper bits are a sign extension or zero.
    always_comb begin
        range_ok = 1'b1;
        case (size_t'(req_size))
            SZ_BYTE: range_ok = req_signed ? (req_data[31:8] == {24{req_data[7]}})
                                           : (req_data[31:8] == '0);
            SZ_HALF: range_ok = req_signed ? (req_data[31:16] == {16{req_data[15]}})
                                           : (req_data[31:16] == '0);
            default: range_ok = 1'b1;
        endcase
    end
`else
    // Without the range check, upper bits are truncated and req_signed has no effect.
    logic unused_signed;
    assign unused_signed = req_signed;

    always_comb begin
        range_ok = 1'b1;
    end
`endif

    // Classify the incoming request; misalignment takes priority over range.
    always_comb begin
        chk_err = ERR_NONE;
        case (size_t'(req_size))
            SZ_BYTE: begin
                if (!range_ok) chk_err = ERR_RANGE;
            end
            SZ_HALF: begin
                if (req_addr[0])    chk_err = ERR_MISALIGN;
                else if (!range_ok) chk_err = ERR_RANGE;
            end
            SZ_WORD: begin
                if (req_addr[1:0] != 2'b00) chk_err = ERR_MISALIGN;
            end
            default: chk_err = ERR_SIZE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            size_q  <= SZ_BYTE;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            size_q  <= size_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: latch on accept, then sequence READ/WRITE/DONE.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        size_d  = size_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d = req_addr;
                    data_d = req_data;
                    size_d = size_t'(req_size);
                    err_d  = chk_err;
                    if (chk_err != ERR_NONE)
                        state_d = DONE;
                    else if (size_t'(req_size) == SZ_WORD)
                        state_d = WRITE;
                    else
                        state_d = READ;
                end
            end
            READ:  state_d = WRITE;
            WRITE: state_d = DONE;
            DONE: begin
                state_d = IDLE;
                err_d   = ERR_NONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Merge the store value into the word read back from memory (little-endian lanes).
    always_comb begin
        merged = mem_rdata;
        case (size_q)
            SZ_BYTE: begin
                for (int unsigned i = 0; i < 4; i++) begin
                    if (addr_q[1:0] == 2'(i)) merged[8*i +: 8] = data_q[7:0];
                end
            end
            SZ_HALF: begin
                if (addr_q[1]) merged[31:16] = data_q[15:0];
                else           merged[15:0]  = data_q[15:0];
            end
            default: merged = data_q;
        endcase
    end

    // Output decode from registered state and latched request.
    always_comb begin
        req_ready  = (state_q == IDLE);
        mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
        mem_re     = (state_q == READ);
        mem_we     = (state_q == WRITE);
        mem_wdata  = '0;
        done_valid = (state_q == DONE);
        done_err   = 1'b0;
        err_code   = ERR_NONE;
        if (state_q == WRITE) mem_wdata = merged;
        if (state_q == DONE) begin
            done_err = (err_q != ERR_NONE);
            err_code = err_q;
        end
    end

endmodule
